// File: rtl/dcd_scan_var.sv
// Decision-variable finder: snapshots NUM_VAR values on start and scans LANES per cycle,
// starting at a round-robin pointer, for the first free variable (value[WIDTH-1:1] == 0).
module dcd_scan_var #(
  parameter int unsigned NUM_VAR = 8,
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned LANES   = 2,
  parameter bit          RR_EN   = 1'b1,
  parameter int unsigned IDX_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_dcd_i,
  input  logic [NUM_VAR*WIDTH-1:0] value_i,
  output logic                     busy_o,
  output logic                     done_dcd_o,
  output logic                     found_o,
  output logic [NUM_VAR-1:0]       index_o,
  output logic [IDX_W-1:0]         var_idx_o
);

  localparam int unsigned SEL_W = (NUM_VAR > 1) ? $clog2(NUM_VAR) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_VAR + 1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e                   state_q, state_d;
  logic [NUM_VAR*WIDTH-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]         base_q, base_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [IDX_W-1:0]         var_idx_q, var_idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     done_q, done_d;
  logic                     found_q, found_d;
  logic [NUM_VAR-1:0]       index_q, index_d;

  logic [NUM_VAR-1:0] free;
  logic [NUM_VAR-1:0] lsb;
  logic               unused_lsb;

  for (genvar i = 0; i < NUM_VAR; i++) begin : g_free
    assign free[i] = (snap_q[i*WIDTH+1 +: WIDTH-1] == '0);
    assign lsb[i]  = snap_q[i*WIDTH];
  end
  assign unused_lsb = ^lsb;

  // Window evaluation: cnt_q is the count already examined; lanes past NUM_VAR are masked.
  logic        hit;
  logic        last;
  logic [31:0] hit_var;
  logic [31:0] off;
  logic [31:0] pos;

  always_comb begin
    hit     = 1'b0;
    hit_var = '0;
    off     = '0;
    pos     = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      off = 32'(cnt_q) + j;
      pos = 32'(base_q) + off;
      if (pos >= NUM_VAR) pos = pos - NUM_VAR;
      if (!hit && (off < NUM_VAR) && free[pos[SEL_W-1:0]]) begin
        hit     = 1'b1;
        hit_var = pos;
      end
    end
  end

  assign last = (32'(cnt_q) + LANES >= NUM_VAR);

  logic [31:0] nxt;

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    found_d   = found_q;
    index_d   = index_q;
    var_idx_d = var_idx_q;
    nxt       = '0;
    unique case (state_q)
      StIdle: begin
        if (start_dcd_i) begin
          state_d   = StScan;
          snap_d    = value_i;
          base_d    = RR_EN ? ptr_q : '0;
          cnt_d     = '0;
          found_d   = 1'b0;
          index_d   = '0;
          var_idx_d = '0;
        end
      end
      StScan: begin
        if (hit) begin
          state_d                    = StIdle;
          done_d                     = 1'b1;
          found_d                    = 1'b1;
          index_d                    = '0;
          index_d[hit_var[SEL_W-1:0]] = 1'b1;
          var_idx_d                  = IDX_W'(hit_var);
          if (RR_EN) begin
            nxt = hit_var + 32'd1;
            if (nxt >= NUM_VAR) nxt = '0;
            ptr_d = IDX_W'(nxt);
          end
        end else if (last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(LANES);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      snap_q    <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      index_q   <= '0;
      var_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
      found_q   <= found_d;
      index_q   <= index_d;
      var_idx_q <= var_idx_d;
    end
  end

  assign busy_o     = (state_q == StScan);
  assign done_dcd_o = done_q;
  assign found_o    = found_q;
  assign index_o    = index_q;
  assign var_idx_o  = var_idx_q;

endmodule

// File: tb/tb_dcd_scan_var.sv
// Directed bench for dcd_scan_var: default instance (8 vars, 2 lanes) and a 5-variable instance.
module tb_dcd_scan_var;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start5;
  logic [23:0] value;
  logic [14:0] value5;
  logic        busy, done, found;
  logic [7:0]  index;
  logic [2:0]  vidx;
  logic        busy5, done5, found5;
  logic [4:0]  index5;
  logic [2:0]  vidx5;

  always #5 clk = ~clk;

  dcd_scan_var u_dut (
    .clk         (clk),
    .rst         (rst),
    .start_dcd_i (start),
    .value_i     (value),
    .busy_o      (busy),
    .done_dcd_o  (done),
    .found_o     (found),
    .index_o     (index),
    .var_idx_o   (vidx)
  );

  dcd_scan_var #(
    .NUM_VAR (5),
    .WIDTH   (3),
    .LANES   (2),
    .RR_EN   (1'b1),
    .IDX_W   (3)
  ) u_dut5 (
    .clk         (clk),
    .rst         (rst),
    .start_dcd_i (start5),
    .value_i     (value5),
    .busy_o      (busy5),
    .done_dcd_o  (done5),
    .found_o     (found5),
    .index_o     (index5),
    .var_idx_o   (vidx5)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int done5_cnt = 0;

  typedef struct {
    logic       found;
    logic [7:0] index;
    logic [2:0] vidx;
    int         lat;
  } exp_t;
  exp_t sb[$];

  // Observation mux selects which instance the current scan drives.
  logic       cur = 1'b0;
  logic       o_busy, o_done, o_found;
  logic [7:0] o_index;
  logic [2:0] o_vidx;
  assign o_busy  = cur ? busy5 : busy;
  assign o_done  = cur ? done5 : done;
  assign o_found = cur ? found5 : found;
  assign o_index = cur ? {3'b000, index5} : index;
  assign o_vidx  = cur ? vidx5 : vidx;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (done5) done5_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Free variables use both zero-status encodings (3'b000 and 3'b001).
  function automatic logic [23:0] vals(input logic [7:0] free_m);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (free_m[i]) r[i*3 +: 3] = (i % 2 == 1) ? 3'b001 : 3'b000;
      else           r[i*3 +: 3] = (i % 2 == 1) ? 3'b100 : 3'b010;
    end
    return r;
  endfunction

  task automatic run_scan(input string tag, input logic sel, input logic [7:0] free_m,
                          input logic disturb, input logic f, input logic [2:0] vi,
                          input int lat);
    exp_t        e, g;
    int          n;
    int          dc0;
    logic [23:0] v;
    v       = vals(free_m);
    e.found = f;
    e.vidx  = f ? vi : 3'd0;
    e.index = f ? (8'd1 << vi) : 8'd0;
    e.lat   = lat;
    sb.push_back(e);
    cur = sel;
    dc0 = sel ? done5_cnt : done_cnt;
    if (sel) begin
      value5 = v[14:0];
      start5 = 1'b1;
    end else begin
      value = v;
      start = 1'b1;
    end
    step();
    start  = 1'b0;
    start5 = 1'b0;
    n = 1;
    while (!o_done && n < 20) begin
      chk({tag, "/busy_scan"}, 32'(o_busy), 32'd1);
      if (disturb && n <= 2) begin
        value = vals(8'h00);
        start = 1'b1;
      end
      step();
      start = 1'b0;
      n++;
    end
    chk({tag, "/done_seen"}, 32'(o_done), 32'd1);
    g = sb.pop_front();
    chk({tag, "/latency"}, 32'(n), 32'(g.lat));
    chk({tag, "/busy_done"}, 32'(o_busy), 32'd0);
    chk({tag, "/found"}, 32'(o_found), 32'(g.found));
    chk({tag, "/index"}, 32'(o_index), 32'(g.index));
    chk({tag, "/var_idx"}, 32'(o_vidx), 32'(g.vidx));
    step();
    chk({tag, "/done_pulse"}, 32'(o_done), 32'd0);
    chk({tag, "/found_hold"}, 32'(o_found), 32'(g.found));
    chk({tag, "/var_idx_hold"}, 32'(o_vidx), 32'(g.vidx));
    chk({tag, "/done_count"}, 32'((sel ? done5_cnt : done_cnt) - dc0), 32'd1);
  endtask

  initial begin
    int dc0;
    rst    = 1'b1;
    start  = 1'b0;
    start5 = 1'b0;
    value  = '0;
    value5 = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/found", 32'(found), 32'd0);
    chk("rst/index", 32'(index), 32'd0);
    chk("rst/var_idx", 32'(vidx), 32'd0);
    chk("rst/busy5", 32'(busy5), 32'd0);

    run_scan("all_free_a", 1'b0, 8'hff, 1'b0, 1'b1, 3'd0, 2);
    run_scan("all_free_b", 1'b0, 8'hff, 1'b0, 1'b1, 3'd1, 2);
    run_scan("only7_p2", 1'b0, 8'h80, 1'b0, 1'b1, 3'd7, 4);
    run_scan("only6_p0", 1'b0, 8'h40, 1'b0, 1'b1, 3'd6, 5);
    run_scan("only6_p7", 1'b0, 8'h40, 1'b0, 1'b1, 3'd6, 5);
    run_scan("wrap70_p7", 1'b0, 8'h81, 1'b0, 1'b1, 3'd7, 2);
    run_scan("only6_p0b", 1'b0, 8'h40, 1'b0, 1'b1, 3'd6, 5);
    run_scan("wrap0_p7", 1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 2);
    run_scan("all_busy", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 5);
    run_scan("ptr_kept", 1'b0, 8'hff, 1'b0, 1'b1, 3'd1, 2);
    run_scan("only7_p2b", 1'b0, 8'h80, 1'b0, 1'b1, 3'd7, 4);
    run_scan("snapshot", 1'b0, 8'h08, 1'b1, 1'b1, 3'd3, 3);

    // Reset two cycles into an all-busy scan: no done pulse, pointer back to 0.
    cur   = 1'b0;
    value = vals(8'h00);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rst_scan/busy_t1", 32'(busy), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    dc0 = done_cnt;
    chk("rst_scan/busy", 32'(busy), 32'd0);
    chk("rst_scan/done", 32'(done), 32'd0);
    chk("rst_scan/found", 32'(found), 32'd0);
    chk("rst_scan/index", 32'(index), 32'd0);
    chk("rst_scan/var_idx", 32'(vidx), 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("rst_scan/no_done", 32'(done_cnt - dc0), 32'd0);
    run_scan("after_rst", 1'b0, 8'hff, 1'b0, 1'b1, 3'd0, 2);

    // Reset together with start: start dropped, outputs and pointer cleared.
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start/busy", 32'(busy), 32'd0);
    chk("rst_start/found", 32'(found), 32'd0);
    chk("rst_start/index", 32'(index), 32'd0);
    step();
    chk("rst_start/idle", 32'(busy), 32'd0);
    chk("rst_start/done", 32'(done), 32'd0);
    run_scan("rst_start_ptr", 1'b0, 8'hff, 1'b0, 1'b1, 3'd0, 2);

    run_scan("n5_only2", 1'b1, 8'h04, 1'b0, 1'b1, 3'd2, 3);
    run_scan("n5_only4_p3", 1'b1, 8'h10, 1'b0, 1'b1, 3'd4, 2);
    run_scan("n5_wrap_p0", 1'b1, 8'h1f, 1'b0, 1'b1, 3'd0, 2);
    run_scan("n5_all_busy", 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcd_scan_var.md
Name: dcd_scan_var

Overview:
Sequential decision-variable finder for the state_list of the SAT engine. On a start pulse it snapshots the value vector of NUM_VAR variables and scans it LANES variables per cycle for the first free (unassigned) variable. The scan begins at a round-robin pointer. The block returns a one-hot and a binary index with a done pulse. It generalises the single-variable lock_cnt decode to N variables, multi-lane scanning, wrap-around and round-robin start.

Parameters:
NUM_VAR, 8, number of variables scanned
WIDTH, 3, bits per variable value; variable free when value[WIDTH-1:1]==0
LANES, 2, variables examined per scan cycle (1..NUM_VAR)
RR_EN, 1, 1 = scan starts after last decided variable; 0 = always start at variable 0
IDX_W, 3, width of binary index (>= clog2(NUM_VAR))

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
start_dcd_i  in  1  start pulse; accepted only when busy_o==0
value_i  in  NUM_VAR*WIDTH  variable values; variable i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH]
busy_o  out  1  scan in progress
done_dcd_o  out  1  one-cycle completion pulse
found_o  out  1  free variable found (valid from done, held)
index_o  out  NUM_VAR  one-hot index of chosen variable, 0 if none
var_idx_o  out  IDX_W  binary index of chosen variable, 0 if none

Behaviour:
- Reset: FSM=IDLE; busy_o, done_dcd_o, found_o = 0; index_o, var_idx_o = 0; round-robin pointer = 0; snapshot cleared.
- FSM states: IDLE, SCAN.
  - IDLE -> SCAN on start_dcd_i (cycle T).
  - SCAN -> IDLE on a hit or when all windows are exhausted.
- At T:
  - value_i is latched into the snapshot. Later changes to value_i do not affect the scan.
  - Scan base = RR_EN ? pointer : 0.
  - Examined count = 0.
  - found_o, index_o and var_idx_o are cleared.
- SCAN cycles T+k, for k = 1..W, with W = ceil(NUM_VAR/LANES):
  - Window k covers variables (base + (k-1)*LANES + j) mod NUM_VAR, for j = 0..LANES-1.
  - Lanes whose overall offset is >= NUM_VAR are masked in the final window, so each variable is examined exactly once.
  - Priority within a window is the lowest j. Lane order follows wrap order, so variable NUM_VAR-1 beats variable 0 in a window that straddles the wrap.
- Hit in window k:
  - At T+k+1: done_dcd_o=1 for one cycle, found_o=1, index_o one-hot, var_idx_o binary, busy_o=0, state IDLE.
  - If RR_EN: pointer = (var_idx+1) mod NUM_VAR.
- No free variable:
  - At T+W+1: done_dcd_o=1, found_o=0, index_o=0, var_idx_o=0.
  - Pointer unchanged.
- busy_o = 1 from T+1 through T+k (the last scan cycle), and 0 in the done cycle.
- A new start is accepted in the done cycle or later.
- start_dcd_i while busy_o==1 is ignored, with no effect on state, pointer or snapshot.
- found_o, index_o and var_idx_o hold their values until the next accepted start or reset.
- rst has priority over everything. rst in the same cycle as start: start is dropped. rst during SCAN: next cycle is IDLE, no done pulse, pointer = 0.
- Index arithmetic: wrap is modulo NUM_VAR, including when NUM_VAR is not a power of 2 (compare-and-subtract, not bit truncation). var_idx_o < NUM_VAR always.
- LANES == NUM_VAR: single-window scan, latency 2 cycles from start to done.

Test Plan:
Defaults are NUM_VAR=8, WIDTH=3, LANES=2, RR_EN=1. "Busy" value = 3'b010. Start is at cycle T.
1. After reset, all variables free, start at T -> done at T+2, found=1, index_o=8'h01, var_idx=0. Second start, same values -> done +2 cycles after start, index_o=8'h02, var_idx=1.
2. Pointer 0, only variable 6 free -> windows {0,1}{2,3}{4,5}{6,7}, done at T+5, index_o=8'h40, var_idx=6. Next start with only variable 6 free: pointer 7, windows {7,0}{1,2}{3,4}{5,6}, done at T+5, var_idx=6, pointer stays 7.
3. All variables busy -> done at T+5, found=0, index_o=0, var_idx=0; busy_o high T+1..T+4; pointer unchanged.
4. Pointer 7, variables 7 and 0 free -> done at T+2, var_idx=7. Same stimulus with only variable 0 free -> var_idx=0, done at T+2. Next pointer is 0 and 1 respectively.
5. value_i switched to all-busy at T+1 after start with variable 3 free -> done at T+3, var_idx=3. Start pulsed at T+1 and T+2 -> ignored, exactly one done pulse.
6. rst at T+2 during a scan with no free variable -> busy_o=0 at T+3, no done pulse, all outputs 0. rst and start together -> stays IDLE. NUM_VAR=5, LANES=2, only variable 4 free, pointer 3 -> windows {3,4}, done at T+2, var_idx=4, next pointer 0.
